// File: rtl/muldiv_seq_pkg.sv
// Shared core configuration: ALU function encodings plus the multi-cycle
// multiply/divide state type and iteration count.
package muldiv_seq_pkg;

  localparam logic [31:0] ZERO = 32'h0000_0000;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  localparam int MULDIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } muldiv_state_e;

  function automatic logic is_m_op(input logic [4:0] f);
    logic r;
    case (f)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [4:0] f);
    logic r;
    case (f)
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic a_is_signed(input logic [4:0] f);
    logic r;
    case (f)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM: r = 1'b1;
      default:                                         r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic b_is_signed(input logic [4:0] f);
    logic r;
    case (f)
      ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// compare-subtract-shift (restoring) for divide. Purely combinational.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN:0]   hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN:0]   hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum_s;
  logic [XLEN+1:0] shl_s;
  logic [XLEN+1:0] diff_s;
  logic            ge_s;

  // Multiply: hi accumulates, product shifts right into lo. Divide: the
  // remainder borrow bit decides whether the trial subtraction is kept.
  always_comb begin
    sum_s  = hi_i + (lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    shl_s  = {hi_i, lo_i[XLEN-1]};
    diff_s = shl_s - {2'b00, opnd_i};
    ge_s   = ~diff_s[XLEN+1];
    if (is_div_i) begin
      hi_o = ge_s ? diff_s[XLEN:0] : shl_s[XLEN:0];
      lo_o = {lo_i[XLEN-2:0], ge_s};
    end else begin
      hi_o = {1'b0, sum_s[XLEN:1]};
      lo_o = {sum_s[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit: operands are reduced to magnitudes,
// iterated one bit per cycle in muldiv_step, then sign-corrected and registered.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      alu_function,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  if (XLEN != 32) begin : g_xlen_check
    $error("muldiv_seq supports XLEN=32 only");
  end

  localparam logic [5:0] STEPS = 6'(MULDIV_STEPS);

  muldiv_state_e   state_q;
  logic [4:0]      func_q;
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] spec_res_q;
  logic [XLEN-1:0] result_q;
  logic [5:0]      cnt_q;
  logic            neg_q, spec_q, busy_q, done_q;

  logic            accept_s, sa_s, sb_s, div_s, div0_s, ovf_s, neg_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s, spec_res_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fin_s;

  // Acceptance decode: magnitudes, sign flags and the early-out cases.
  always_comb begin
    accept_s = start && is_m_op(alu_function) && (state_q != RUN);
    sa_s     = a_is_signed(alu_function) && operand_a[XLEN-1];
    sb_s     = b_is_signed(alu_function) && operand_b[XLEN-1];
    mag_a_s  = sa_s ? (~operand_a + {{(XLEN-1){1'b0}}, 1'b1}) : operand_a;
    mag_b_s  = sb_s ? (~operand_b + {{(XLEN-1){1'b0}}, 1'b1}) : operand_b;
    div_s    = is_div_op(alu_function);
    div0_s   = div_s && (operand_b == {XLEN{1'b0}});
    ovf_s    = ((alu_function == ALU_DIV) || (alu_function == ALU_REM)) &&
               (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == {XLEN{1'b1}});
    // Remainder follows the dividend; quotient and products follow the sign XOR.
    neg_s    = (alu_function == ALU_REM) ? sa_s : (sa_s ^ sb_s);
    if (div0_s) begin
      spec_res_s = ((alu_function == ALU_DIV) || (alu_function == ALU_DIVU)) ?
                   {XLEN{1'b1}} : operand_a;
    end else if (ovf_s) begin
      spec_res_s = (alu_function == ALU_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : {XLEN{1'b0}};
    end else begin
      spec_res_s = {XLEN{1'b0}};
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div_op(func_q)),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (hi_d),
    .lo_o     (lo_d)
  );

  // Sign fix and result selection applied on the completion cycle.
  always_comb begin
    prod_s = {hi_q[XLEN-1:0], lo_q};
    if (neg_q) begin
      prod_s = ~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1};
    end else begin
      prod_s = prod_s;
    end
    quo_s = neg_q ? (~lo_q + {{(XLEN-1){1'b0}}, 1'b1}) : lo_q;
    rem_s = neg_q ? (~hi_q[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1}) : hi_q[XLEN-1:0];
    case (func_q)
      ALU_MUL:                        fin_s = prod_s[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: fin_s = prod_s[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:              fin_s = quo_s;
      ALU_REM, ALU_REMU:              fin_s = rem_s;
      default:                        fin_s = {XLEN{1'b0}};
    endcase
    if (spec_q) begin
      fin_s = spec_res_q;
    end else begin
      fin_s = fin_s;
    end
  end

  // Control FSM, iteration counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      func_q     <= 5'd0;
      hi_q       <= {(XLEN+1){1'b0}};
      lo_q       <= {XLEN{1'b0}};
      opnd_q     <= {XLEN{1'b0}};
      spec_res_q <= {XLEN{1'b0}};
      result_q   <= ZERO;
      cnt_q      <= 6'd0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FINISH: begin
          done_q <= 1'b0;
          if (accept_s) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            func_q     <= alu_function;
            neg_q      <= neg_s;
            spec_q     <= div0_s || ovf_s;
            spec_res_q <= spec_res_s;
            hi_q       <= {(XLEN+1){1'b0}};
            lo_q       <= div_s ? mag_a_s : mag_b_s;
            opnd_q     <= div_s ? mag_b_s : mag_a_s;
            // Early-out cases jump the counter so the next cycle completes.
            cnt_q      <= (FAST_SPECIAL && (div0_s || ovf_s)) ? STEPS : 6'd0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q == STEPS) begin
            state_q  <= FINISH;
            result_q <= fin_s;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle-level reference model checked every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  alu_function = ALU_ADD;
  logic [31:0] operand_a = 32'h0;
  logic [31:0] operand_b = 32'h0;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  muldiv_seq #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .alu_function (alu_function),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p, ua64, ub64;
    logic [31:0] r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'h0, b});
    ua64 = {32'h0, a};
    ub64 = {32'h0, b};
    r    = 32'h0;
    case (f)
      ALU_MUL:    begin p = 64'(sa * sb); r = p[31:0];  end
      ALU_MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
      ALU_MULHSU: begin p = 64'(sa * ub); r = p[63:32]; end
      ALU_MULHU:  begin p = ua64 * ub64;  r = p[63:32]; end
      ALU_DIV: begin
        if (b == 32'h0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = 64'(sa / sb); r = p[31:0]; end
      end
      ALU_DIVU: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM: begin
        if (b == 32'h0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = 64'(sa % sb); r = p[31:0]; end
      end
      ALU_REMU: r = (b == 32'h0) ? a : a % b;
      default:  r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic bit is_m(input logic [4:0] f);
    return (f >= ALU_MUL) && (f <= ALU_REMU);
  endfunction

  function automatic int latency(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    bit dv, sp;
    dv = (f >= ALU_DIV) && (f <= ALU_REMU);
    sp = dv && ((b == 32'h0) ||
                ((f == ALU_DIV || f == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return sp ? 1 : 33;
  endfunction

  // Cycle model: what busy/done/result must show after the next rising edge.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_result = 32'h0, m_pend = 32'h0;
  int          m_left = 0;

  always @(negedge clock) begin
    chk("busy", {31'h0, busy}, {31'h0, m_busy});
    chk("done", {31'h0, done}, {31'h0, m_done});
    chk("result", result, m_result);
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_result = 32'h0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_result = m_pend;
        end
      end else if (start && is_m(alu_function)) begin
        m_busy = 1'b1;
        m_pend = model(alu_function, operand_a, operand_b);
        m_left = latency(alu_function, operand_a, operand_b);
      end
    end
  end

  // Issue one op from #1 after an edge; returns #1 after the done edge.
  task automatic run_op(input string name, input logic [4:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    n = 0;
    start = 1'b1; alu_function = f; operand_a = a; operand_b = b;
    @(posedge clock); #1;
    start = 1'b0; alu_function = ALU_ADD; operand_a = ~a; operand_b = ~b;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    chk({name, "_lat"}, 32'(n), 32'(lat));
    chk({name, "_res"}, result, exp);
  endtask

  task automatic dir_op(input string name, input logic [4:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    chk({name, "_mdl"}, model(f, a, b), exp);
    run_op(name, f, a, b, exp, lat);
    @(posedge clock); #1;
  endtask

  initial begin
    int n;
    logic [4:0]  f;
    logic [31:0] a, b;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", result, 32'h0);

    dir_op("mul",     ALU_MUL,    32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    dir_op("mulh",    ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    dir_op("mulhu",   ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    dir_op("mulhsu",  ALU_MULHSU, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33);
    dir_op("mulh_n",  ALU_MULH,   32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 33);
    dir_op("div",     ALU_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33);
    dir_op("rem",     ALU_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33);
    dir_op("div_pn",  ALU_DIV,    32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    dir_op("rem_pn",  ALU_REM,    32'h7,         32'hFFFF_FFFE, 32'h1,         33);
    dir_op("divu",    ALU_DIVU,   32'hFFFF_FFFE, 32'h2,         32'h7FFF_FFFF, 33);
    dir_op("remu",    ALU_REMU,   32'd10,        32'd3,         32'd1,         33);
    dir_op("div0",    ALU_DIV,    32'd5,         32'h0,         32'hFFFF_FFFF, 1);
    dir_op("remu0",   ALU_REMU,   32'd9,         32'h0,         32'd9,         1);
    dir_op("div_ovf", ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    dir_op("rem_ovf", ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

    // Back-to-back: second start issued in the done cycle of the first.
    run_op("b2b_1", ALU_DIVU,  32'd100, 32'd7, 32'd14, 33);
    run_op("b2b_2", ALU_MULHU, 32'hFFFF_FFFF, 32'h2, 32'h1, 33);
    @(posedge clock); #1;

    // start during busy must be ignored.
    start = 1'b1; alu_function = ALU_DIV; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1 start = 1'b1; alu_function = ALU_MUL; operand_a = 32'd3; operand_b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    n = 5;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    chk("busy_start_lat", 32'(n), 32'd33);
    chk("busy_start_res", result, 32'd14);
    repeat (2) @(posedge clock);

    // Non-M function with start is ignored.
    #1 start = 1'b1; alu_function = ALU_ADD; operand_a = 32'd1; operand_b = 32'd2;
    @(posedge clock); #1;
    start = 1'b0;
    chk("add_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(posedge clock);

    // Reset sampled at E10 of a DIV abandons it.
    #1 start = 1'b1; alu_function = ALU_DIV; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    chk("rstmid_result", result, 32'h0);
    repeat (40) @(posedge clock);
    #1;
    dir_op("after_rst", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);

    // Random operands, with div-by-zero and overflow mixed in.
    for (int i = 0; i < 160; i++) begin
      f = 5'(32'(ALU_MUL) + $urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = b & 32'h0000_00FF;
        default: ;
      endcase
      run_op("rnd", f, a, b, model(f, a, b), latency(f, a, b));
    end
    @(posedge clock); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
